// File: rtl/accum_iter_scheduler.sv
// Round-robin owner of the shared accumulator engine: grants one requester ITER_COUNT passes.
// Optional per-pass watchdog is built only when ITER_SCHED_TIMEOUT_EN is defined.
module accum_iter_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ITER_COUNT     = 30,
    parameter int unsigned CNT_W          = 6,
    parameter int unsigned GID_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] in_req,
    input  logic               in_accumCalcDoneFlag,
    output logic               op_enableAccumCalc,
    output logic               op_grantValid,
    output logic [GID_W-1:0]   op_grantId,
    output logic [NUM_REQ-1:0] op_reqDone,
    output logic               op_busy,
    output logic               op_timeoutErr
);

    typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} stateT;

    stateT              stateQ, stateD;
    logic [GID_W-1:0]   rrPtrQ, rrPtrD;
    logic [CNT_W-1:0]   iterCntQ, iterCntD;
    logic [GID_W-1:0]   grantIdQ, grantIdD;
    logic               grantValidQ, grantValidD;
    logic               enableQ, enableD;
    logic [NUM_REQ-1:0] reqDoneQ, reqDoneD;
    logic               busyQ;

    logic               anyReq;
    logic [GID_W-1:0]   winner;
    logic [GID_W-1:0]   nextPtr;
    logic               reqHeld;
    logic               wdExpired;

    assign anyReq  = |in_req;
    assign reqHeld = in_req[grantIdQ];
    assign nextPtr = (32'(grantIdQ) == NUM_REQ - 1) ? '0 : grantIdQ + GID_W'(1);

    // Later loop overrides the earlier one, so a set bit at or above rrPtr beats a wrapped one.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (in_req[i]) winner = GID_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (in_req[i] && (i >= int'(rrPtrQ))) winner = GID_W'(i);
        end
    end

`ifdef ITER_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdCntQ, wdCntD;
    logic            timeoutErrQ, timeoutErrD;

    // Counter is zero in the first cycle of every pass since it is cleared outside RUN.
    assign wdCntD      = (stateQ == StRun) ? wdCntQ + WD_W'(1) : '0;
    assign wdExpired   = (wdCntQ == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeoutErrD = (stateQ == StRun) && reqHeld && !in_accumCalcDoneFlag && wdExpired;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdCntQ      <= '0;
            timeoutErrQ <= 1'b0;
        end else begin
            wdCntQ      <= wdCntD;
            timeoutErrQ <= timeoutErrD;
        end
    end

    assign op_timeoutErr = timeoutErrQ;
`else
    logic unusedTimeout;

    assign unusedTimeout = ^TIMEOUT_CYCLES;
    assign wdExpired     = 1'b0;
    assign op_timeoutErr = 1'b0;
`endif

    // State register plus the registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ      <= StIdle;
            rrPtrQ      <= '0;
            iterCntQ    <= '0;
            grantIdQ    <= '0;
            grantValidQ <= 1'b0;
            enableQ     <= 1'b0;
            reqDoneQ    <= '0;
            busyQ       <= 1'b0;
        end else begin
            stateQ      <= stateD;
            rrPtrQ      <= rrPtrD;
            iterCntQ    <= iterCntD;
            grantIdQ    <= grantIdD;
            grantValidQ <= grantValidD;
            enableQ     <= enableD;
            reqDoneQ    <= reqDoneD;
            busyQ       <= (stateD != StIdle);
        end
    end

    // Next-state logic; a dropped request beats a done flag, which beats the watchdog.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: if (anyReq) stateD = StRun;
            StRun: begin
                if (!reqHeld) begin
                    stateD = StIdle;
                end else if (in_accumCalcDoneFlag) begin
                    stateD = (iterCntQ == '0) ? StDone : StGap;
                end else if (wdExpired) begin
                    stateD = StIdle;
                end
            end
            StGap:   stateD = reqHeld ? StRun : StIdle;
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        rrPtrD      = rrPtrQ;
        iterCntD    = iterCntQ;
        grantIdD    = grantIdQ;
        grantValidD = grantValidQ;
        enableD     = enableQ;
        reqDoneD    = '0;
        unique case (stateQ)
            StIdle: begin
                if (anyReq) begin
                    grantValidD = 1'b1;
                    grantIdD    = winner;
                    enableD     = 1'b1;
                    iterCntD    = CNT_W'(ITER_COUNT - 1);
                end
            end
            StRun: begin
                if (!reqHeld || (!in_accumCalcDoneFlag && wdExpired)) begin
                    enableD     = 1'b0;
                    grantValidD = 1'b0;
                    rrPtrD      = nextPtr;
                end else if (in_accumCalcDoneFlag) begin
                    enableD = 1'b0;
                    if (iterCntQ == '0) begin
                        grantValidD        = 1'b0;
                        reqDoneD[grantIdQ] = 1'b1;
                        rrPtrD             = nextPtr;
                    end else begin
                        iterCntD = iterCntQ - CNT_W'(1);
                    end
                end
            end
            StGap: begin
                if (!reqHeld) begin
                    enableD     = 1'b0;
                    grantValidD = 1'b0;
                    rrPtrD      = nextPtr;
                end else begin
                    enableD = 1'b1;
                end
            end
            StDone: begin
                enableD     = 1'b0;
                grantValidD = 1'b0;
            end
            default: begin
                enableD     = 1'b0;
                grantValidD = 1'b0;
            end
        endcase
    end

    assign op_enableAccumCalc = enableQ;
    assign op_grantValid      = grantValidQ;
    assign op_grantId         = grantIdQ;
    assign op_reqDone         = reqDoneQ;
    assign op_busy            = busyQ;

endmodule

// File: tb/tb_accum_iter_scheduler.sv
// Directed bench for accum_iter_scheduler with NUM_REQ=4, ITER_COUNT=3, TIMEOUT_CYCLES=16.
module tb_accum_iter_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] in_req;
    logic       in_accumCalcDoneFlag;
    logic       op_enableAccumCalc;
    logic       op_grantValid;
    logic [1:0] op_grantId;
    logic [3:0] op_reqDone;
    logic       op_busy;
    logic       op_timeoutErr;

    int errors = 0;
    int checks = 0;
    int riseCnt = 0;

    accum_iter_scheduler #(
        .NUM_REQ       (4),
        .ITER_COUNT    (3),
        .CNT_W         (2),
        .GID_W         (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .in_req              (in_req),
        .in_accumCalcDoneFlag(in_accumCalcDoneFlag),
        .op_enableAccumCalc  (op_enableAccumCalc),
        .op_grantValid       (op_grantValid),
        .op_grantId          (op_grantId),
        .op_reqDone          (op_reqDone),
        .op_busy             (op_busy),
        .op_timeoutErr       (op_timeoutErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge op_enableAccumCalc) riseCnt++;

    initial begin
        #200000;
        $display("FAIL timeLimit: observed=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b1;
        #1;
        check("resetIdle", {op_busy, op_grantValid, op_enableAccumCalc, op_reqDone}, 0);
        #1;
        reset = 1'b0;
    endtask

    // Entered one cycle after the grant edge; runs three passes and the DONE cycle.
    task automatic serveGrant(input logic [1:0] expId, input int passLen,
                              input logic [3:0] reqAfterDone);
        int base;
        base = riseCnt;
        check("grantValid", op_grantValid, 1);
        check("grantId", op_grantId, expId);
        check("grantEnable", op_enableAccumCalc, 1);
        for (int p = 0; p < 3; p++) begin
            repeat (passLen - 1) begin
                tick;
                check("passEnable", op_enableAccumCalc, 1);
            end
            in_accumCalcDoneFlag = 1'b1;
            tick;
            in_accumCalcDoneFlag = 1'b0;
            if (p < 2) begin
                check("gapState", {op_enableAccumCalc, op_grantValid, op_reqDone}, 32'h10);
                tick;
                check("gapEnd", op_enableAccumCalc, 1);
            end else begin
                check("doneReq", op_reqDone, 32'(1) << expId);
                check("doneState", {op_enableAccumCalc, op_grantValid, op_busy}, 3'b001);
                check("doneIdKept", op_grantId, expId);
                check("doneNoTimeout", op_timeoutErr, 0);
                in_req = reqAfterDone;
                tick;
                check("afterDone", {op_reqDone, op_busy}, 0);
            end
        end
        check("enableRises", riseCnt - base, 2);
    endtask

    initial begin
        reset = 1'b1;
        in_req = 4'b0000;
        in_accumCalcDoneFlag = 1'b0;
        #1;
        check("resetOutputs", {op_enableAccumCalc, op_grantValid, op_grantId, op_reqDone,
                               op_busy, op_timeoutErr}, 0);
        tick;
        reset = 1'b0;
        check("idleAfterReset", {op_busy, op_grantValid}, 0);

        // Single requester, flag five cycles into each pass.
        in_req = 4'b0010;
        tick;
        serveGrant(2'd1, 5, 4'b0000);

        // Round robin with requesters leaving after service: 0, 1, 3.
        doReset;
        in_req = 4'b1011;
        tick;
        serveGrant(2'd0, 2, 4'b1010);
        tick;
        serveGrant(2'd1, 2, 4'b1000);
        tick;
        serveGrant(2'd3, 2, 4'b0000);

        // All four held: 0, 1, 2, 3, 0.
        doReset;
        in_req = 4'b1111;
        tick;
        serveGrant(2'd0, 2, 4'b1111);
        tick;
        serveGrant(2'd1, 2, 4'b1111);
        tick;
        serveGrant(2'd2, 2, 4'b1111);
        tick;
        serveGrant(2'd3, 2, 4'b1111);
        tick;
        serveGrant(2'd0, 2, 4'b0000);

        // Abort in the second pass; next search starts at 3.
        doReset;
        in_req = 4'b0100;
        tick;
        check("abortGrant", op_grantId, 2);
        tick;
        in_accumCalcDoneFlag = 1'b1;
        tick;
        in_accumCalcDoneFlag = 1'b0;
        check("abortGap", op_enableAccumCalc, 0);
        tick;
        check("abortPass2", op_enableAccumCalc, 1);
        tick;
        in_req = 4'b1001;
        tick;
        check("abortState", {op_enableAccumCalc, op_grantValid, op_reqDone, op_busy}, 0);
        tick;
        check("abortNextId", op_grantId, 3);
        check("abortNextValid", {op_grantValid, op_reqDone}, 5'h10);
        in_req = 4'b0000;

        // Flag held into GAP must not count as a pass.
        doReset;
        in_req = 4'b0001;
        tick;
        check("spurGrant", op_grantId, 0);
        tick;
        in_accumCalcDoneFlag = 1'b1;
        tick;
        check("spurGap", op_enableAccumCalc, 0);
        tick;
        in_accumCalcDoneFlag = 1'b0;
        check("spurGapEnd", {op_enableAccumCalc, op_grantValid}, 2'b11);
        tick;
        in_accumCalcDoneFlag = 1'b1;
        tick;
        in_accumCalcDoneFlag = 1'b0;
        check("spurSecondGap", {op_enableAccumCalc, op_grantValid, op_reqDone}, 32'h10);
        tick;
        check("spurPass3", op_enableAccumCalc, 1);
        tick;
        in_accumCalcDoneFlag = 1'b1;
        tick;
        in_accumCalcDoneFlag = 1'b0;
        check("spurDone", op_reqDone, 4'b0001);
        in_req = 4'b0000;
        tick;

        // Flag in IDLE is ignored, then a full run still takes three passes.
        in_accumCalcDoneFlag = 1'b1;
        tick;
        tick;
        check("idleFlag", {op_busy, op_enableAccumCalc, op_grantValid}, 0);
        in_accumCalcDoneFlag = 1'b0;
        in_req = 4'b0010;
        tick;
        serveGrant(2'd1, 2, 4'b0000);

        // Done flag and request drop together: abort, no done pulse.
        in_req = 4'b0100;
        tick;
        check("coincGrant", op_grantId, 2);
        tick;
        tick;
        tick;
        in_accumCalcDoneFlag = 1'b1;
        in_req = 4'b0000;
        tick;
        in_accumCalcDoneFlag = 1'b0;
        check("coincAbort", {op_enableAccumCalc, op_grantValid, op_reqDone, op_busy}, 0);
        tick;
        check("coincNoPulse", {op_reqDone, op_busy}, 0);

        // Async reset between edges in the middle of a pass.
        doReset;
        in_req = 4'b0010;
        tick;
        serveGrant(2'd1, 2, 4'b0000);
        in_req = 4'b0100;
        tick;
        check("rstGrant", op_grantId, 2);
        tick;
        tick;
        #2;
        reset = 1'b1;
        #1;
        check("rstMidRun", {op_enableAccumCalc, op_grantValid, op_grantId, op_reqDone,
                            op_busy, op_timeoutErr}, 0);
        #2;
        reset = 1'b0;
        in_req = 4'b1111;
        tick;
        check("rstRegrant", {op_grantValid, op_grantId}, 3'b100);
        in_req = 4'b0000;
        doReset;

`ifdef ITER_SCHED_TIMEOUT_EN
        // Flag never comes: 16 enable cycles then a one-cycle timeout pulse.
        in_req = 4'b0001;
        tick;
        check("toEnable1", op_enableAccumCalc, 1);
        for (int i = 2; i <= 16; i++) begin
            tick;
            check("toEnable", {op_enableAccumCalc, op_timeoutErr}, 2'b10);
        end
        tick;
        check("toPulse", {op_timeoutErr, op_grantValid, op_enableAccumCalc, op_reqDone}, 7'h40);
        in_req = 4'b0000;
        tick;
        check("toPulseEnd", {op_timeoutErr, op_busy}, 0);
`else
        // Without the watchdog, RUN waits indefinitely.
        in_req = 4'b0001;
        tick;
        repeat (40) tick;
        check("noWatchdog", {op_enableAccumCalc, op_grantValid, op_timeoutErr}, 3'b110);
        in_req = 4'b0000;
        tick;
        check("noWatchdogAbort", {op_grantValid, op_timeoutErr, op_reqDone}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
